// File: rtl/hv_assoc_pkg.sv
// Shared types and default sizing for the hypervector associative-memory search.
// Imported by the search top level.
package hv_assoc_pkg;

    localparam int DefHVDimension = 512;
    localparam int DefNumClass    = 32;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StSearch = 2'd1;
    localparam state_t StDone   = 2'd2;

endpackage

// File: rtl/hv_popcount.sv
// Combinational adder-tree popcount: W input bits, $clog2(W)+1 output bits.
// The input is split in half recursively, and the two half-counts are summed at each level.
module hv_popcount #(
    parameter int W = 8
) (
    input  logic [W-1:0]       i_bits,
    output logic [$clog2(W):0] o_count
);

    localparam int OW = $clog2(W) + 1;

    if (W == 1) begin : g_leaf
        assign o_count = i_bits;
    end else begin : g_split
        localparam int WL = W / 2;
        localparam int WH = W - WL;

        logic [$clog2(WL):0] w_lo;
        logic [$clog2(WH):0] w_hi;

        hv_popcount #(.W(WL)) u_lo (
            .i_bits  (i_bits[WL-1:0]),
            .o_count (w_lo)
        );

        hv_popcount #(.W(WH)) u_hi (
            .i_bits  (i_bits[W-1:WL]),
            .o_count (w_hi)
        );

        assign o_count = OW'(w_lo) + OW'(w_hi);
    end

endmodule

// File: rtl/hv_assoc_search.sv
// Sequential nearest-class search. Class hypervectors stream from external memory at one per cycle.
// The minimum Hamming distance is tracked, and ties keep the lowest index.
module hv_assoc_search
    import hv_assoc_pkg::*;
#(
    parameter int HVDimension    = DefHVDimension,
    parameter int NumClass       = DefNumClass,
    parameter int ClassAddrWidth = $clog2(NumClass),
    parameter int DistWidth      = $clog2(HVDimension) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [HVDimension-1:0]    query_i,
    input  logic                      query_valid_i,
    output logic                      query_ready_o,
    input  logic [ClassAddrWidth:0]   num_class_i,
    output logic                      class_req_o,
    output logic [ClassAddrWidth-1:0] class_addr_o,
    input  logic [HVDimension-1:0]    class_data_i,
    output logic [ClassAddrWidth-1:0] predict_o,
    output logic [DistWidth-1:0]      dist_o,
    output logic                      predict_valid_o,
    input  logic                      predict_ready_i,
    output logic                      busy_o
);

    localparam logic [ClassAddrWidth:0] NMax = (ClassAddrWidth + 1)'(NumClass);
    localparam logic [ClassAddrWidth:0] NOne = (ClassAddrWidth + 1)'(1);

    state_t                    r_state;
    logic [HVDimension-1:0]    r_query;
    logic [ClassAddrWidth:0]   r_n;
    logic [ClassAddrWidth:0]   r_cnt;
    logic                      r_req;
    logic [ClassAddrWidth-1:0] r_addr;
    logic                      r_dvalid;
    logic [ClassAddrWidth-1:0] r_daddr;
    logic [DistWidth-1:0]      r_min;
    logic [ClassAddrWidth-1:0] r_idx;
    logic [DistWidth-1:0]      r_dist;
    logic [ClassAddrWidth-1:0] r_pred;
    logic                      r_pvalid;

    logic [ClassAddrWidth:0]   w_n_eff;
    logic [ClassAddrWidth:0]   w_n_m1;
    logic [DistWidth-1:0]      w_dist;
    logic [DistWidth-1:0]      w_min_nx;
    logic [ClassAddrWidth-1:0] w_idx_nx;
    logic                      w_last;

    hv_popcount #(.W(HVDimension)) u_popcount (
        .i_bits  (r_query ^ class_data_i),
        .o_count (w_dist)
    );

    // Clamp the requested class count: zero or out-of-range means search every class.
    always_comb begin
        w_n_eff = num_class_i;
        if ((num_class_i == '0) || (num_class_i > NMax)) begin
            w_n_eff = NMax;
        end else begin
            w_n_eff = num_class_i;
        end
    end

    // Strict less-than update, so an equal distance never displaces an earlier index.
    always_comb begin
        w_min_nx = r_min;
        w_idx_nx = r_idx;
        if (r_dvalid && (w_dist < r_min)) begin
            w_min_nx = w_dist;
            w_idx_nx = r_daddr;
        end else begin
            w_min_nx = r_min;
            w_idx_nx = r_idx;
        end
    end

    assign w_n_m1 = r_n - NOne;
    assign w_last = r_dvalid && (r_daddr == w_n_m1[ClassAddrWidth-1:0]);

    // Search FSM: issue reads, track the minimum, and hold the result until it is consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= StIdle;
            r_query  <= '0;
            r_n      <= '0;
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_min    <= '1;
            r_idx    <= '0;
            r_dist   <= '0;
            r_pred   <= '0;
            r_pvalid <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_pvalid <= 1'b0;
                    if (query_valid_i) begin
                        r_query <= query_i;
                        r_n     <= w_n_eff;
                        r_cnt   <= NOne;
                        r_req   <= 1'b1;
                        r_addr  <= '0;
                        r_min   <= '1;
                        r_idx   <= '0;
                        r_state <= StSearch;
                    end else begin
                        r_req   <= 1'b0;
                    end
                end
                StSearch: begin
                    if (r_cnt < r_n) begin
                        r_req  <= 1'b1;
                        r_addr <= r_cnt[ClassAddrWidth-1:0];
                        r_cnt  <= r_cnt + NOne;
                    end else begin
                        r_req  <= 1'b0;
                    end
                    r_min <= w_min_nx;
                    r_idx <= w_idx_nx;
                    if (w_last) begin
                        r_state  <= StDone;
                        r_pvalid <= 1'b1;
                        r_pred   <= w_idx_nx;
                        r_dist   <= w_min_nx;
                    end else begin
                        r_pvalid <= 1'b0;
                    end
                end
                StDone: begin
                    r_req <= 1'b0;
                    if (predict_ready_i) begin
                        r_pvalid <= 1'b0;
                        r_state  <= StIdle;
                    end else begin
                        r_pvalid <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_req    <= 1'b0;
                    r_pvalid <= 1'b0;
                end
            endcase
        end
    end

    // Delay the request by one cycle to mark when the returned memory data is valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dvalid <= 1'b0;
            r_daddr  <= '0;
        end else begin
            r_dvalid <= r_req;
            r_daddr  <= r_addr;
        end
    end

    assign query_ready_o   = (r_state == StIdle);
    assign busy_o          = (r_state == StSearch) || (r_state == StDone);
    assign class_req_o     = r_req;
    assign class_addr_o    = r_addr;
    assign predict_o       = r_pred;
    assign dist_o          = r_dist;
    assign predict_valid_o = r_pvalid;

endmodule

// File: tb/tb_hv_assoc_search.sv
// Directed self-checking bench for hv_assoc_search.
// An external class memory with one-cycle read latency is modelled, and every result is checked against hand-derived values.
module tb_hv_assoc_search;

    logic         clk_i;
    logic         rst_ni;
    logic [511:0] query_i;
    logic         query_valid_i;
    logic         query_ready_o;
    logic [5:0]   num_class_i;
    logic         class_req_o;
    logic [4:0]   class_addr_o;
    logic [511:0] class_data_i;
    logic [4:0]   predict_o;
    logic [9:0]   dist_o;
    logic         predict_valid_o;
    logic         predict_ready_i;
    logic         busy_o;

    logic [511:0] mem [32];
    int checks;
    int failures;

    hv_assoc_search dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .query_i         (query_i),
        .query_valid_i   (query_valid_i),
        .query_ready_o   (query_ready_o),
        .num_class_i     (num_class_i),
        .class_req_o     (class_req_o),
        .class_addr_o    (class_addr_o),
        .class_data_i    (class_data_i),
        .predict_o       (predict_o),
        .dist_o          (dist_o),
        .predict_valid_o (predict_valid_o),
        .predict_ready_i (predict_ready_i),
        .busy_o          (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Class memory: data follows the read strobe by one cycle.
    always @(posedge clk_i) begin
        if (class_req_o) class_data_i <= mem[class_addr_o];
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [511:0] rand_hv();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Accept one query, then follow the request stream up to the first cycle in which the result is valid.
    task automatic do_search(input logic [511:0] q, input logic [5:0] num,
                             input int exp_pred, input int exp_dist, input int exp_n);
        int nreq;
        int lat;
        @(negedge clk_i);
        query_i       = q;
        num_class_i   = num;
        query_valid_i = 1'b1;
        chk("ready_before_accept", 32'(query_ready_o), 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        query_valid_i = 1'b0;
        query_i       = ~q;
        num_class_i   = 6'd1;
        nreq = 0;
        lat  = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) @(negedge clk_i);
            if (cyc == 1) chk("ready_low_busy", 32'(query_ready_o), 32'd0);
            if (class_req_o) begin
                chk("req_addr", 32'(class_addr_o), 32'(nreq));
                chk("req_cycle", 32'(cyc), 32'(nreq + 1));
                nreq++;
            end
            if (predict_valid_o) begin
                lat = cyc;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(exp_n + 2));
        chk("req_count", 32'(nreq), 32'(exp_n));
        chk("predict", 32'(predict_o), 32'(exp_pred));
        chk("dist", 32'(dist_o), 32'(exp_dist));
        chk("busy_done", 32'(busy_o), 32'd1);
    endtask

    task automatic handshake();
        predict_ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        predict_ready_i = 1'b0;
        chk("ready_after_hs", 32'(query_ready_o), 32'd1);
        chk("pvalid_after_hs", 32'(predict_valid_o), 32'd0);
    endtask

    initial begin
        logic [511:0] q;
        logic         seen;
        checks          = 0;
        failures        = 0;
        rst_ni          = 1'b0;
        query_i         = rand_hv();
        query_valid_i   = 1'(($urandom & 1) != 0);
        num_class_i     = 6'($urandom);
        predict_ready_i = 1'(($urandom & 1) != 0);
        class_data_i    = '0;
        for (int k = 0; k < 32; k++) mem[k] = rand_hv();

        // Reset state
        repeat (3) @(negedge clk_i);
        chk("rst_query_ready", 32'(query_ready_o), 32'd1);
        chk("rst_class_req", 32'(class_req_o), 32'd0);
        chk("rst_class_addr", 32'(class_addr_o), 32'd0);
        chk("rst_predict", 32'(predict_o), 32'd0);
        chk("rst_dist", 32'(dist_o), 32'd0);
        chk("rst_pvalid", 32'(predict_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        query_valid_i   = 1'b0;
        predict_ready_i = 1'b0;
        rst_ni          = 1'b1;
        @(negedge clk_i);
        chk("post_rst_ready", 32'(query_ready_o), 32'd1);

        // Exact match against class 2
        do_search(mem[2], 6'd4, 2, 0, 4);
        handshake();

        // Tie between class 1 and class 3, both at distance 5
        q = rand_hv();
        mem[0] = ~q;
        mem[1] = q ^ 512'h1F;
        mem[2] = q ^ {{384{1'b0}}, {128{1'b1}}};
        mem[3] = q ^ (512'h1F << 100);
        do_search(q, 6'd4, 1, 5, 4);

        // Backpressure: the result stays put and the new query is refused
        predict_ready_i = 1'b0;
        query_valid_i   = 1'b1;
        query_i         = rand_hv();
        num_class_i     = 6'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            chk("bp_pvalid", 32'(predict_valid_o), 32'd1);
            chk("bp_predict", 32'(predict_o), 32'd1);
            chk("bp_dist", 32'(dist_o), 32'd5);
            chk("bp_ready", 32'(query_ready_o), 32'd0);
        end
        query_valid_i = 1'b0;
        handshake();
        q = rand_hv();
        mem[0] = q ^ 512'hFF;
        mem[1] = q ^ 512'h3;
        do_search(q, 6'd2, 1, 2, 2);
        handshake();

        // Single class, fully inverted
        q = rand_hv();
        mem[0] = ~q;
        do_search(q, 6'd1, 0, 512, 1);
        handshake();

        // Zero count and out-of-range count both search all 32 classes
        q = rand_hv();
        for (int k = 0; k < 32; k++) mem[k] = ~q;
        mem[20] = q ^ 512'h7;
        mem[31] = q ^ 512'hF;
        do_search(q, 6'd0, 20, 3, 32);
        handshake();
        do_search(q, 6'd63, 20, 3, 32);
        handshake();

        // Abort a 16-class search in cycle 3
        @(negedge clk_i);
        query_i       = q;
        num_class_i   = 6'd16;
        query_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        query_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_req_before", 32'(class_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("abort_req", 32'(class_req_o), 32'd0);
        chk("abort_pvalid", 32'(predict_valid_o), 32'd0);
        chk("abort_ready", 32'(query_ready_o), 32'd1);
        chk("abort_busy", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk_i);
            if (predict_valid_o || class_req_o) seen = 1'b1;
        end
        chk("abort_no_result", 32'(seen), 32'd0);
        for (int k = 0; k < 32; k++) mem[k] = rand_hv();
        do_search(mem[9], 6'd16, 9, 0, 16);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
